// File: rtl/sprite_fetch_engine.sv
// Two-stage sprite pixel fetch: drives a shared ROM address, selects the addressed
// slot's palette index, and alternates animated sprites between two slots on vsync.
module sprite_fetch_engine #(
   parameter int NUM_ROMS = 16,
   parameter int ADDR_W   = 10,
   parameter int PIX_W    = 3,
   parameter int SEL_W    = 5,
   parameter int ANIM_DIV = 30
) (
   input  logic                      axi_aclk,
   input  logic                      axi_aresetn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [SEL_W-1:0]          req_code,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic                      req_anim,
   input  logic                      vsync_pulse,
   input  logic                      anim_hold,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [NUM_ROMS*PIX_W-1:0] rom_q,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [PIX_W-1:0]          out_data,
   output logic                      out_oob,
   output logic                      anim_phase
);

   localparam logic [SEL_W:0] NUM_ROMS_L = (SEL_W + 1)'(NUM_ROMS);
   localparam logic [7:0]     ANIM_LAST  = 8'(ANIM_DIV - 1);

   logic               run_r;
   logic               s1_valid_r;
   logic [SEL_W:0]     s1_eff_r;
   logic [ADDR_W-1:0]  s1_addr_r;
   logic               out_valid_r;
   logic [PIX_W-1:0]   out_data_r;
   logic               out_oob_r;
   logic [7:0]         anim_cnt_r;
   logic               anim_phase_r;

   logic               s2_load_s;
   logic               s1_load_s;
   logic               accept_s;
   logic [SEL_W:0]     eff_s;
   logic               s1_oob_s;
   logic [PIX_W-1:0]   sel_pix_s;

   // run_r keeps req_ready low while reset is held and releases it one edge later
   assign s2_load_s = !out_valid_r || out_ready;
   assign s1_load_s = run_r && (s2_load_s || !s1_valid_r);
   assign accept_s  = req_valid && s1_load_s;
   assign eff_s     = {1'b0, req_code} + {{SEL_W{1'b0}}, req_anim & anim_phase_r};
   assign s1_oob_s  = (s1_eff_r >= NUM_ROMS_L);

   // One-hot OR mux over ROM slots; an out-of-range code matches no slot
   always_comb begin
      sel_pix_s = '0;
      for (int k = 0; k < NUM_ROMS; k++) begin
         sel_pix_s = sel_pix_s |
                     (rom_q[k*PIX_W +: PIX_W] & {PIX_W{s1_eff_r == (SEL_W + 1)'(k)}});
      end
   end

   // Fetch pipeline: S1 holds address/effective code, S2 holds the returned pixel
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         run_r       <= 1'b0;
         s1_valid_r  <= 1'b0;
         s1_eff_r    <= '0;
         s1_addr_r   <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_oob_r   <= 1'b0;
      end else begin
         run_r <= 1'b1;
         if (s1_load_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
               s1_eff_r  <= eff_s;
               s1_addr_r <= req_addr;
            end else begin
               s1_eff_r  <= s1_eff_r;
               s1_addr_r <= s1_addr_r;
            end
         end else begin
            s1_valid_r <= s1_valid_r;
         end
         if (s2_load_s) begin
            out_valid_r <= s1_valid_r;
            out_data_r  <= (s1_valid_r && !s1_oob_s) ? sel_pix_s : '0;
            out_oob_r   <= s1_valid_r && s1_oob_s;
         end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_oob_r   <= out_oob_r;
         end
      end
   end

   // Animation divider: counts vsync pulses and flips the phase every ANIM_DIV of them
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         anim_cnt_r   <= 8'd0;
         anim_phase_r <= 1'b0;
      end else if (vsync_pulse && !anim_hold) begin
         if (anim_cnt_r == ANIM_LAST) begin
            anim_cnt_r   <= 8'd0;
            anim_phase_r <= !anim_phase_r;
         end else begin
            anim_cnt_r   <= anim_cnt_r + 8'd1;
            anim_phase_r <= anim_phase_r;
         end
      end else begin
         anim_cnt_r   <= anim_cnt_r;
         anim_phase_r <= anim_phase_r;
      end
   end

   assign req_ready  = s1_load_s;
   assign rom_addr   = s1_addr_r;
   assign out_valid  = out_valid_r;
   assign out_data   = out_data_r;
   assign out_oob    = out_oob_r;
   assign anim_phase = anim_phase_r;

endmodule

// File: tb/tb_sprite_fetch_engine.sv
// Bench for sprite_fetch_engine (10 ROM slots, ANIM_DIV=3): vector table, scoreboard
// fed at request acceptance, and directed sequences for stalls, animation and reset.
module tb_sprite_fetch_engine;

   localparam int NR = 10;
   localparam int AW = 10;
   localparam int PW = 3;
   localparam int SW = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            req_valid = 1'b0;
   logic [SW-1:0]   req_code = '0;
   logic [AW-1:0]   req_addr = '0;
   logic            req_anim = 1'b0;
   logic            vsync_pulse = 1'b0;
   logic            anim_hold = 1'b0;
   logic            out_ready = 1'b0;
   logic            req_ready;
   logic [AW-1:0]   rom_addr;
   logic [NR*PW-1:0] rom_q;
   logic            out_valid;
   logic [PW-1:0]   out_data;
   logic            out_oob;
   logic            anim_phase;

   typedef struct {
      logic [PW-1:0] d;
      logic          oob;
      int            cyc;
   } sb_t;

   typedef struct {
      logic [SW-1:0] code;
      logic [AW-1:0] addr;
      logic          anim;
      logic [PW-1:0] exp_d;
      logic          exp_oob;
   } vec_t;

   sb_t  q[$];
   vec_t vec[7];

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   m_cnt = 0;
   logic m_phase = 1'b0;
   logic m_run = 1'b0;
   logic last_acc = 1'b0;
   logic last_pop = 1'b0;
   logic [PW-1:0] last_d = '0;
   logic last_oob = 1'b0;
   bit   lat_chk = 1'b0;

   sprite_fetch_engine #(
      .NUM_ROMS(NR), .ADDR_W(AW), .PIX_W(PW), .SEL_W(SW), .ANIM_DIV(3)
   ) dut (
      .axi_aclk(clk), .axi_aresetn(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code),
      .req_addr(req_addr), .req_anim(req_anim),
      .vsync_pulse(vsync_pulse), .anim_hold(anim_hold),
      .rom_addr(rom_addr), .rom_q(rom_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_oob(out_oob), .anim_phase(anim_phase)
   );

   always #5 clk = ~clk;

   // ROM contents: every slot/address combination gets a distinct-ish palette index
   function automatic logic [PW-1:0] pix(input int k, input logic [AW-1:0] a);
      logic [PW-1:0] t;
      t = PW'(k * 3) + a[2:0] + (a[9:7] ^ a[5:3]);
      return t;
   endfunction

   always_comb begin
      rom_q = '0;
      for (int k = 0; k < NR; k++) rom_q[k*PW +: PW] = pix(k, rom_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // Sample at the falling edge, update scoreboard/model, then advance to posedge+1
   task automatic tick();
      sb_t  e;
      int   eff;
      logic exp_rdy;
      @(negedge clk);
      last_acc = 1'b0;
      last_pop = 1'b0;
      if (!rst_n) begin
         q.delete();
         m_cnt   = 0;
         m_phase = 1'b0;
      end else begin
         if (m_run) check("anim_phase", anim_phase, m_phase);
         exp_rdy = m_run && !(q.size() >= 2 && !out_ready);
         check("req_ready", req_ready, exp_rdy);
         if (m_run && q.size() == 0) check("out_valid_idle", out_valid, 1'b0);
         if (q.size() == 2) check("out_valid_full", out_valid, 1'b1);
         if (out_valid && out_ready) begin
            last_pop = 1'b1;
            last_d   = out_data;
            last_oob = out_oob;
            if (q.size() == 0) begin
               fail("sb_underflow");
            end else begin
               e = q.pop_front();
               check("sb_data", out_data, e.d);
               check("sb_oob", out_oob, e.oob);
               if (lat_chk) check("latency", cyc - e.cyc, 2);
            end
         end
         if (req_valid && req_ready) begin
            last_acc = 1'b1;
            eff   = int'(req_code) + ((req_anim && m_phase) ? 1 : 0);
            e.oob = (eff >= NR);
            e.d   = e.oob ? '0 : pix(eff, req_addr);
            e.cyc = cyc;
            q.push_back(e);
         end
         if (vsync_pulse && !anim_hold) begin
            if (m_cnt == 2) begin
               m_cnt   = 0;
               m_phase = !m_phase;
            end else begin
               m_cnt++;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      m_run = rst_n;
   endtask

   task automatic send(input logic [SW-1:0] c, input logic [AW-1:0] a, input logic an);
      req_valid = 1'b1;
      req_code  = c;
      req_addr  = a;
      req_anim  = an;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (last_acc) break;
      end
      if (!last_acc) fail("send_timeout");
      req_valid = 1'b0;
   endtask

   task automatic wait_out();
      for (int i = 0; i < 50; i++) begin
         tick();
         if (last_pop) break;
      end
      if (!last_pop) fail("wait_out_timeout");
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (q.size() == 0 && !out_valid) break;
         tick();
      end
      if (q.size() != 0 || out_valid) fail("drain_timeout");
   endtask

   task automatic pulse();
      vsync_pulse = 1'b1;
      tick();
      vsync_pulse = 1'b0;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t0;
      int n;
      int guard;

      vec[0] = '{5'd0,  10'h000, 1'b0, pix(0, 10'h000), 1'b0};
      vec[1] = '{5'd9,  10'h3FF, 1'b0, pix(9, 10'h3FF), 1'b0};
      vec[2] = '{5'd9,  10'h155, 1'b1, pix(9, 10'h155), 1'b0};
      vec[3] = '{5'd10, 10'h2AA, 1'b0, 3'd0,            1'b1};
      vec[4] = '{5'd31, 10'h001, 1'b0, 3'd0,            1'b1};
      vec[5] = '{5'd5,  10'h0F0, 1'b1, pix(5, 10'h0F0), 1'b0};
      vec[6] = '{5'd4,  10'h207, 1'b0, pix(4, 10'h207), 1'b0};

      // reset state
      repeat (3) tick();
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 3'd0);
      check("rst_out_oob", out_oob, 1'b0);
      check("rst_rom_addr", rom_addr, 10'd0);
      check("rst_anim_phase", anim_phase, 1'b0);
      rst_n = 1'b1;
      tick();
      check("post_rst_req_ready", req_ready, 1'b1);

      // streaming at full rate, codes 0..9
      out_ready = 1'b1;
      lat_chk   = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 10; i++)
         send(SW'(i), (i == 9) ? 10'h3FF : AW'(i * 97), 1'b0);
      check("stream_cycles", cyc - t0, 10);
      wait_idle();
      lat_chk = 1'b0;

      // vector table (phase 0)
      for (int i = 0; i < 7; i++) begin
         send(vec[i].code, vec[i].addr, vec[i].anim);
         wait_out();
         check("vec_data", last_d, vec[i].exp_d);
         check("vec_oob", last_oob, vec[i].exp_oob);
      end

      // random backpressure
      n = 0;
      guard = 0;
      while (n < 500 && guard < 5000) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_code  = SW'($urandom_range(0, NR - 1));
         req_addr  = AW'($urandom);
         req_anim  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         tick();
         if (last_acc) n++;
         guard++;
      end
      req_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();
      check("bp_accepted", n, 500);

      // animation: toggles after pulses 3 and 6, frozen by anim_hold
      send(5'd7, 10'h123, 1'b1);
      wait_out();
      check("anim_slot7_a", last_d, pix(7, 10'h123));
      repeat (3) pulse();
      check("phase_after3", anim_phase, 1'b1);
      send(5'd7, 10'h123, 1'b1);
      wait_out();
      check("anim_slot8", last_d, pix(8, 10'h123));
      repeat (3) pulse();
      check("phase_after6", anim_phase, 1'b0);
      send(5'd7, 10'h123, 1'b1);
      wait_out();
      check("anim_slot7_b", last_d, pix(7, 10'h123));
      pulse();
      check("phase_after7", anim_phase, 1'b0);
      anim_hold = 1'b1;
      repeat (3) pulse();
      check("phase_hold", anim_phase, 1'b0);
      anim_hold = 1'b0;
      repeat (2) pulse();
      check("phase_after_hold", anim_phase, 1'b1);

      // out-of-bounds with phase 1
      send(5'd9, 10'h2AA, 1'b1);
      wait_out();
      check("oob10_data", last_d, 3'd0);
      check("oob10_flag", last_oob, 1'b1);
      send(5'd31, 10'h001, 1'b1);
      wait_out();
      check("oob32_data", last_d, 3'd0);
      check("oob32_flag", last_oob, 1'b1);
      send(5'd8, 10'h001, 1'b1);
      wait_out();
      check("eff9_data", last_d, pix(9, 10'h001));
      check("eff9_flag", last_oob, 1'b0);

      // asynchronous reset with both stages full
      out_ready = 1'b0;
      send(5'd2, 10'h005, 1'b0);
      send(5'd3, 10'h0C6, 1'b0);
      check("pre_rst_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_out_data", out_data, 3'd0);
      check("mid_rst_rom_addr", rom_addr, 10'd0);
      check("mid_rst_anim_phase", anim_phase, 1'b0);
      check("mid_rst_req_ready", req_ready, 1'b0);
      check("mid_rst_out_oob", out_oob, 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (5) tick();

      // phase toggle edge coincides with request acceptance
      repeat (2) pulse();
      vsync_pulse = 1'b1;
      req_valid = 1'b1;
      req_code  = 5'd3;
      req_addr  = 10'h0AB;
      req_anim  = 1'b1;
      tick();
      check("boundary_accept", last_acc, 1'b1);
      vsync_pulse = 1'b0;
      req_valid = 1'b0;
      wait_out();
      check("boundary_pre_phase", last_d, pix(3, 10'h0AB));
      check("boundary_phase", anim_phase, 1'b1);
      send(5'd3, 10'h0AB, 1'b1);
      wait_out();
      check("boundary_new_phase", last_d, pix(4, 10'h0AB));

      wait_idle();
      check("sb_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
